// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter (fetch m0, load m1) sharing one AR/R channel to memory.
// Latency: request seen in idle at cycle N drives s_arvalid_o at N+1; AR/R are pass-through.
// Backpressure: no buffering; arready/rready are combinational pass-throughs of the other side.
//
// Ports:
//   clock, reset               : system clock, synchronous active-high reset
//   m0_ar*/m0_r*               : fetch/icache refill read port (AXI4 AR/R subset)
//   m1_ar*/m1_r*               : LSU load read port (same shape as m0)
//   s_ar*/s_r*                 : read port towards the memory crossbar
//   busy_o                     : a transaction is in flight
//   grant_o                    : current owner, or last owner when idle (0 = m0, 1 = m1)
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_araddr_i,
  input  logic [LEN_W-1:0]  m0_arlen_i,
  input  logic              m0_arvalid_i,
  output logic              m0_arready_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [1:0]        m0_rresp_o,
  output logic              m0_rlast_o,
  output logic              m0_rvalid_o,
  input  logic              m0_rready_i,

  input  logic [ADDR_W-1:0] m1_araddr_i,
  input  logic [LEN_W-1:0]  m1_arlen_i,
  input  logic              m1_arvalid_i,
  output logic              m1_arready_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [1:0]        m1_rresp_o,
  output logic              m1_rlast_o,
  output logic              m1_rvalid_o,
  input  logic              m1_rready_i,

  output logic [ADDR_W-1:0] s_araddr_o,
  output logic [LEN_W-1:0]  s_arlen_o,
  output logic              s_arvalid_o,
  input  logic              s_arready_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [1:0]        s_rresp_i,
  input  logic              s_rlast_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o,

  output logic              busy_o,
  output logic              grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ar_req_t;

  state_t  state_q, state_d;
  logic    grant_q, grant_d;
  logic    last_grant_q, last_grant_d;
  logic    any_req;
  logic    winner;
  logic    r_done;
  ar_req_t m0_req, m1_req, sel_req;

  assign m0_req  = {m0_araddr_i, m0_arlen_i};
  assign m1_req  = {m1_araddr_i, m1_arlen_i};
  assign sel_req = grant_q ? m1_req : m0_req;

  // Round-robin: a lone requester wins; on a tie the master that did not
  // own the previous transaction wins. Only consulted in idle.
  always_comb begin
    any_req = m0_arvalid_i | m1_arvalid_i;
    if (m0_arvalid_i && m1_arvalid_i) begin
      winner = ~last_grant_q;
    end else begin
      winner = m1_arvalid_i;
    end
  end

  // The burst ends on the handshake of the beat carrying rlast; the grant
  // stays locked until then, even if error responses come back earlier.
  assign r_done = (state_q == ST_DATA) && s_rvalid_i && s_rready_o && s_rlast_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b1;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s_arready_i) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_done) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel muxing depends only on state and grant, so there is no
  // combinational path from a master's arvalid to s_arvalid_o.
  always_comb begin
    s_arvalid_o  = 1'b0;
    s_araddr_o   = '0;
    s_arlen_o    = '0;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    s_rready_o   = 1'b0;
    m0_rvalid_o  = 1'b0;
    m0_rdata_o   = '0;
    m0_rresp_o   = '0;
    m0_rlast_o   = 1'b0;
    m1_rvalid_o  = 1'b0;
    m1_rdata_o   = '0;
    m1_rresp_o   = '0;
    m1_rlast_o   = 1'b0;

    if (state_q == ST_ADDR) begin
      s_arvalid_o = 1'b1;
      s_araddr_o  = sel_req.addr;
      s_arlen_o   = sel_req.len;
      if (grant_q) begin
        m1_arready_o = s_arready_i;
      end else begin
        m0_arready_o = s_arready_i;
      end
    end

    if (state_q == ST_DATA) begin
      if (grant_q) begin
        s_rready_o  = m1_rready_i;
        m1_rvalid_o = s_rvalid_i;
        m1_rdata_o  = s_rdata_i;
        m1_rresp_o  = s_rresp_i;
        m1_rlast_o  = s_rlast_i;
      end else begin
        s_rready_o  = m0_rready_i;
        m0_rvalid_o = s_rvalid_i;
        m0_rdata_o  = s_rdata_i;
        m0_rresp_o  = s_rresp_i;
        m0_rlast_o  = s_rlast_i;
      end
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign grant_o = grant_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios with literal expectations,
// then randomized masters/memory checked every cycle against a transaction model.
module tb_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_araddr_i, m1_araddr_i, s_araddr_o;
  logic [LEN_W-1:0]  m0_arlen_i, m1_arlen_i, s_arlen_o;
  logic              m0_arvalid_i, m1_arvalid_i, m0_arready_o, m1_arready_o;
  logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o, s_rdata_i;
  logic [1:0]        m0_rresp_o, m1_rresp_o, s_rresp_i;
  logic              m0_rlast_o, m1_rlast_o, s_rlast_i;
  logic              m0_rvalid_o, m1_rvalid_o, s_rvalid_i;
  logic              m0_rready_i, m1_rready_i, s_rready_o;
  logic              s_arvalid_o, s_arready_i;
  logic              busy_o, grant_o;

  always #5 clock = ~clock;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .m0_araddr_i(m0_araddr_i), .m0_arlen_i(m0_arlen_i), .m0_arvalid_i(m0_arvalid_i),
    .m0_arready_o(m0_arready_o), .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o),
    .m0_rlast_o(m0_rlast_o), .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i),
    .m1_araddr_i(m1_araddr_i), .m1_arlen_i(m1_arlen_i), .m1_arvalid_i(m1_arvalid_i),
    .m1_arready_o(m1_arready_o), .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o),
    .m1_rlast_o(m1_rlast_o), .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i),
    .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o), .s_arvalid_o(s_arvalid_o),
    .s_arready_i(s_arready_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i),
    .s_rlast_i(s_rlast_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transaction-level model: is a read open, has its address been taken,
  // who owns it, and who owned the one before.
  logic txn_open, txn_issued, txn_owner, prev_owner;

  logic              exp_s_arvalid;
  logic [ADDR_W-1:0] exp_s_araddr;
  logic [LEN_W-1:0]  exp_s_arlen;
  logic [1:0]        exp_arready;
  logic              exp_s_rready;
  logic [1:0]        exp_rvalid, exp_rlast;
  logic [1:0]        exp_rresp [2];
  logic [DATA_W-1:0] exp_rdata [2];

  always_comb begin
    exp_s_arvalid = 1'b0;
    exp_s_araddr  = '0;
    exp_s_arlen   = '0;
    exp_arready   = 2'b00;
    exp_s_rready  = 1'b0;
    exp_rvalid    = 2'b00;
    exp_rlast     = 2'b00;
    exp_rresp[0]  = '0;
    exp_rresp[1]  = '0;
    exp_rdata[0]  = '0;
    exp_rdata[1]  = '0;
    if (txn_open && !txn_issued) begin
      exp_s_arvalid          = 1'b1;
      exp_s_araddr           = txn_owner ? m1_araddr_i : m0_araddr_i;
      exp_s_arlen            = txn_owner ? m1_arlen_i : m0_arlen_i;
      exp_arready[txn_owner] = s_arready_i;
    end
    if (txn_open && txn_issued) begin
      exp_s_rready          = txn_owner ? m1_rready_i : m0_rready_i;
      exp_rvalid[txn_owner] = s_rvalid_i;
      exp_rlast[txn_owner]  = s_rlast_i;
      exp_rresp[txn_owner]  = s_rresp_i;
      exp_rdata[txn_owner]  = s_rdata_i;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      txn_open   <= 1'b0;
      txn_issued <= 1'b0;
      txn_owner  <= 1'b1;
      prev_owner <= 1'b1;
    end else if (!txn_open) begin
      if (m0_arvalid_i || m1_arvalid_i) begin
        txn_open   <= 1'b1;
        txn_issued <= 1'b0;
        txn_owner  <= (m0_arvalid_i && m1_arvalid_i) ? ~prev_owner : m1_arvalid_i;
      end
    end else if (!txn_issued) begin
      if (s_arready_i) txn_issued <= 1'b1;
    end else if (s_rvalid_i && exp_s_rready && s_rlast_i) begin
      txn_open   <= 1'b0;
      prev_owner <= txn_owner;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ar_channel",
          64'({s_arvalid_o, s_araddr_o, s_arlen_o, m1_arready_o, m0_arready_o}),
          64'({exp_s_arvalid, exp_s_araddr, exp_s_arlen, exp_arready[1], exp_arready[0]}));
      chk("m0_r_channel", 64'({m0_rvalid_o, m0_rlast_o, m0_rresp_o, m0_rdata_o}),
          64'({exp_rvalid[0], exp_rlast[0], exp_rresp[0], exp_rdata[0]}));
      chk("m1_r_channel", 64'({m1_rvalid_o, m1_rlast_o, m1_rresp_o, m1_rdata_o}),
          64'({exp_rvalid[1], exp_rlast[1], exp_rresp[1], exp_rdata[1]}));
      chk("status", 64'({busy_o, grant_o, s_rready_o}),
          64'({txn_open, txn_owner, exp_s_rready}));
    end
  end

  // Memory and master stimulus state.
  bit         mem_active, rand_mode, rereq;
  logic [LEN_W-1:0] mem_len;
  int         mem_beat, ar_cnt, ar_wait, r_prob;

  // Advance one clock: note the handshakes of the ending cycle, then drive
  // the memory/master reaction for the next one.
  task automatic tick();
    logic rst_s, ar_hs, r_hs, r_last, hs0, hs1;
    logic [LEN_W-1:0] hs_len;
    @(negedge clock);
    rst_s  = reset;
    ar_hs  = exp_s_arvalid && s_arready_i;
    hs_len = exp_s_arlen;
    r_hs   = s_rvalid_i && exp_s_rready;
    r_last = s_rlast_i;
    hs0    = m0_arvalid_i && exp_arready[0];
    hs1    = m1_arvalid_i && exp_arready[1];
    @(posedge clock);
    #1;
    if (rst_s) begin
      mem_active = 1'b0; mem_beat = 0; ar_cnt = 0;
      s_arready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0; s_rlast_i = 1'b0;
      m0_arvalid_i = 1'b0; m1_arvalid_i = 1'b0;
    end else begin
      if (hs0) begin
        if (rereq) m0_araddr_i = m0_araddr_i + 32'd4; else m0_arvalid_i = 1'b0;
      end
      if (hs1) begin
        if (rereq) m1_araddr_i = m1_araddr_i + 32'd4; else m1_arvalid_i = 1'b0;
      end
      if (ar_hs) begin
        mem_active = 1'b1; mem_len = hs_len; mem_beat = 0;
        if (rand_mode) ar_wait = int'($urandom_range(3, 0));
      end
      if (r_hs) begin
        mem_beat++;
        s_rvalid_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0; s_rlast_i = 1'b0;
        if (r_last) mem_active = 1'b0;
      end
      if (exp_s_arvalid) begin
        ar_cnt++;
        s_arready_i = (ar_cnt > ar_wait);
      end else begin
        ar_cnt = 0;
        s_arready_i = rand_mode ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      if (mem_active && !s_rvalid_i && (int'($urandom_range(99, 0)) < r_prob)) begin
        s_rvalid_i = 1'b1;
        s_rdata_i  = $urandom;
        s_rresp_i  = 2'($urandom_range(3, 0));
        s_rlast_i  = (mem_beat == int'(mem_len));
      end
      if (rand_mode) begin
        if (!m0_arvalid_i && $urandom_range(99, 0) < 30) begin
          m0_arvalid_i = 1'b1; m0_araddr_i = $urandom; m0_arlen_i = LEN_W'($urandom_range(3, 0));
        end
        if (!m1_arvalid_i && $urandom_range(99, 0) < 30) begin
          m1_arvalid_i = 1'b1; m1_araddr_i = $urandom; m1_arlen_i = LEN_W'($urandom_range(3, 0));
        end
        m0_rready_i = ($urandom_range(99, 0) < 75);
        m1_rready_i = ($urandom_range(99, 0) < 75);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    m0_rready_i = 1'b1;
    m1_rready_i = 1'b1;
    while ((txn_open || m0_arvalid_i || m1_arvalid_i) && k < 100) begin
      tick();
      k++;
    end
    #1;
    chk("drain_idle", 64'(busy_o), 64'(0));
  endtask

  logic rr_seen [4];
  logic rr_req  [4];
  logic [DATA_W-1:0] b0;
  int   n_rr;

  initial begin
    reset = 1'b1;
    m0_araddr_i = '0; m0_arlen_i = '0; m0_arvalid_i = 1'b0; m0_rready_i = 1'b0;
    m1_araddr_i = '0; m1_arlen_i = '0; m1_arvalid_i = 1'b0; m1_rready_i = 1'b0;
    s_arready_i = 1'b0; s_rdata_i = '0; s_rresp_i = '0; s_rlast_i = 1'b0; s_rvalid_i = 1'b0;
    mem_active = 1'b0; mem_len = '0; mem_beat = 0; ar_cnt = 0;
    ar_wait = 0; r_prob = 100; rand_mode = 1'b0; rereq = 1'b0;
    rr_req[0] = 1'b0; rr_req[1] = 1'b1; rr_req[2] = 1'b0; rr_req[3] = 1'b1;

    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    tick();
    #1;
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_grant", 64'(grant_o), 64'(1));
    chk("reset_arvalid", 64'(s_arvalid_o), 64'(0));

    // Single fetch: arlen=3, memory waits two cycles before arready.
    ar_wait = 2; m0_rready_i = 1'b1; m1_rready_i = 1'b0;
    m0_araddr_i = 32'h8000_0000; m0_arlen_i = 8'd3; m0_arvalid_i = 1'b1;
    tick(); #1;
    chk("fetch_araddr", 64'(s_araddr_o), 64'h8000_0000);
    chk("fetch_arlen", 64'(s_arlen_o), 64'd3);
    chk("fetch_grant", 64'(grant_o), 64'(0));
    chk("fetch_arready_wait", 64'(m0_arready_o), 64'(0));
    tick(); tick(); #1;
    chk("fetch_arready", 64'(m0_arready_o), 64'(1));
    for (int b = 0; b < 4; b++) begin
      tick(); #1;
      chk("fetch_beat_vld", 64'(m0_rvalid_o), 64'(1));
      chk("fetch_beat_last", 64'(m0_rlast_o), 64'(b == 3));
      chk("fetch_m1_quiet", 64'(m1_rvalid_o), 64'(0));
    end
    tick(); #1;
    chk("fetch_done_busy", 64'(busy_o), 64'(0));

    // Simultaneous request straight after reset: m0 first, then m1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ar_wait = 0; m0_rready_i = 1'b1; m1_rready_i = 1'b1;
    m0_araddr_i = 32'h0000_1000; m0_arlen_i = '0; m0_arvalid_i = 1'b1;
    m1_araddr_i = 32'h0000_2000; m1_arlen_i = '0; m1_arvalid_i = 1'b1;
    tick(); #1;
    chk("tie_grant0", 64'(grant_o), 64'(0));
    chk("tie_addr0", 64'(s_araddr_o), 64'h1000);
    chk("tie_m1_held", 64'(m1_arready_o), 64'(0));
    tick(); #1;
    chk("tie_m0_last", 64'(m0_rlast_o), 64'(1));
    tick(); #1;
    chk("tie_turnaround_idle", 64'(busy_o), 64'(0));
    tick(); #1;
    chk("tie_grant1", 64'(grant_o), 64'(1));
    chk("tie_addr1", 64'(s_araddr_o), 64'h2000);
    drain();

    // Round-robin with both masters re-requesting single beats.
    rereq = 1'b1;
    m0_araddr_i = 32'h100; m0_arlen_i = '0; m0_arvalid_i = 1'b1;
    m1_araddr_i = 32'h200; m1_arlen_i = '0; m1_arvalid_i = 1'b1;
    n_rr = 0;
    for (int k = 0; k < 40 && n_rr < 4; k++) begin
      tick(); #1;
      if (s_arvalid_o && s_arready_i) begin
        rr_seen[n_rr] = grant_o;
        n_rr++;
      end
    end
    rereq = 1'b0;
    chk("rr_count", 64'(n_rr), 64'd4);
    for (int i = 0; i < 4 && i < n_rr; i++) chk("rr_grant", 64'(rr_seen[i]), 64'(rr_req[i]));
    drain();

    // Backpressure: m1 two-beat burst, rready low for 3 cycles on beat 0.
    m1_rready_i = 1'b0;
    m1_araddr_i = 32'h3000; m1_arlen_i = 8'd1; m1_arvalid_i = 1'b1;
    tick();
    tick();
    b0 = s_rdata_i;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rvalid", 64'(m1_rvalid_o), 64'(1));
      chk("bp_s_rready", 64'(s_rready_o), 64'(0));
      chk("bp_data_stable", 64'(m1_rdata_o), 64'(b0));
      tick();
    end
    m1_rready_i = 1'b1;
    #1;
    chk("bp_release", 64'(s_rready_o), 64'(1));
    chk("bp_release_data", 64'(m1_rdata_o), 64'(b0));
    tick(); #1;
    chk("bp_last", 64'(m1_rlast_o), 64'(1));
    tick(); #1;
    chk("bp_done", 64'(busy_o), 64'(0));
    drain();

    // Late m1 request while m0 is streaming data.
    m0_araddr_i = 32'h5000; m0_arlen_i = 8'd3; m0_arvalid_i = 1'b1;
    tick();
    tick();
    m1_araddr_i = 32'h4000; m1_arlen_i = '0; m1_arvalid_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("late_m1_held", 64'(m1_arready_o), 64'(0));
      if (b == 3) chk("late_m0_last", 64'(m0_rlast_o), 64'(1));
      tick();
    end
    #1;
    chk("late_gap_idle", 64'(busy_o), 64'(0));
    chk("late_gap_arvalid", 64'(s_arvalid_o), 64'(0));
    tick(); #1;
    chk("late_issue_arvalid", 64'(s_arvalid_o), 64'(1));
    chk("late_issue_grant", 64'(grant_o), 64'(1));
    chk("late_issue_addr", 64'(s_araddr_o), 64'h4000);
    drain();

    // Reset during beat 2 of a 4-beat fetch.
    m0_araddr_i = 32'h6000; m0_arlen_i = 8'd3; m0_arvalid_i = 1'b1;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_beat", 64'(m0_rvalid_o), 64'(1));
    tick(); #1;
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_s_rready", 64'(s_rready_o), 64'(0));
    chk("rst_rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'(0));
    chk("rst_grant", 64'(grant_o), 64'(1));
    reset = 1'b0;
    tick();

    // Randomized traffic with occasional resets.
    rand_mode = 1'b1;
    r_prob = 60;
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(399, 0) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
